// File: rtl/run_ctrl_pkg.sv
// Shared types for the core run/halt/step controller.
// States, halt causes and the EBREAK encoding used by the optional ebreak trap.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_STEP   = 2'd0,
    CAUSE_HALT   = 2'd1,
    CAUSE_BP     = 2'd2,
    CAUSE_EBREAK = 2'd3
  } halt_cause_e;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step controller producing the commit enable for the single-cycle core.
// Optional ebreak trap is compiled in with `define RUN_CTRL_EBREAK_EN.
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned START_HALTED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      ins,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  input  logic [CNT_W-1:0] step_count,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instret,
  output run_state_e       dbg_state
);

  // Handshake: none; halt_req is a level, resume_req/step_req are one-cycle
  // pulses honoured only in HALTED, and core_en=1 means the current PC commits
  // at the next rising edge.

  localparam run_state_e RESET_STATE = (START_HALTED != 0) ? HALTED : RUN;

  run_state_e       r_state, w_state_nxt;
  halt_cause_e      r_cause, w_cause_nxt;
  logic             r_halted;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_step_cnt, w_step_cnt_nxt;
  logic             r_skip_bp, w_skip_bp_nxt;

  logic w_bp_hit;
  logic w_ebreak_hit;
  logic w_active;

  assign w_bp_hit = bp_en & (pc == bp_addr) & ~r_skip_bp;

`ifdef RUN_CTRL_EBREAK_EN
  assign w_ebreak_hit = (ins == EBREAK_INSN) & ~r_skip_bp;
`else
  logic w_unused_ins;
  assign w_unused_ins = ^ins;
  assign w_ebreak_hit = 1'b0;
`endif

  assign w_active = (r_state == RUN) | (r_state == STEP);
  assign core_en  = w_active & ~halt_req & ~w_bp_hit & ~w_ebreak_hit;

  always_comb begin
    w_state_nxt    = r_state;
    w_cause_nxt    = r_cause;
    w_step_cnt_nxt = r_step_cnt;
    w_skip_bp_nxt  = r_skip_bp;
    // The first real commit consumes the breakpoint/ebreak bypass.
    if (core_en) w_skip_bp_nxt = 1'b0;
    unique case (r_state)
      HALTED: begin
        if (!halt_req) begin
          if (step_req) begin
            w_state_nxt    = STEP;
            w_step_cnt_nxt = (step_count == '0) ? CNT_W'(1) : step_count;
            w_skip_bp_nxt  = 1'b1;
          end else if (resume_req) begin
            w_state_nxt   = RUN;
            w_skip_bp_nxt = 1'b1;
          end
        end
      end
      RUN, STEP: begin
        if (halt_req) begin
          w_state_nxt    = HALTED;
          w_cause_nxt    = CAUSE_HALT;
          w_step_cnt_nxt = '0;
        end else if (w_bp_hit) begin
          w_state_nxt    = HALTED;
          w_cause_nxt    = CAUSE_BP;
          w_step_cnt_nxt = '0;
        end else if (w_ebreak_hit) begin
          w_state_nxt    = HALTED;
          w_cause_nxt    = CAUSE_EBREAK;
          w_step_cnt_nxt = '0;
        end else if (r_state == STEP) begin
          w_step_cnt_nxt = r_step_cnt - CNT_W'(1);
          if (r_step_cnt == CNT_W'(1)) begin
            w_state_nxt = HALTED;
            w_cause_nxt = CAUSE_STEP;
          end
        end
      end
      default: begin
        w_state_nxt    = HALTED;
        w_step_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RESET_STATE;
      r_halted   <= (START_HALTED != 0);
      r_cause    <= CAUSE_STEP;
      r_instret  <= '0;
      r_step_cnt <= '0;
      r_skip_bp  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_halted   <= (w_state_nxt == HALTED);
      r_cause    <= w_cause_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_skip_bp  <= w_skip_bp_nxt;
      if (core_en) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign halted     = r_halted;
  assign halt_cause = r_cause;
  assign instret    = r_instret;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios then random debug-host traffic,
// every cycle compared against a behavioural model of the run/halt/step rules.
module tb_core_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_MASK = 32'h0000_003F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic [XLEN-1:0]  pc = '0;
  logic [31:0]      ins = NOP;
  logic             halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
  logic [CNT_W-1:0] step_count = '0;
  logic             bp_en = 1'b0;
  logic [XLEN-1:0]  bp_addr = '0;

  logic             core_en, halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] instret;
  run_state_e       dbg_state;

  logic             core_en_h, halted_h;
  logic [1:0]       halt_cause_h;
  logic [CNT_W-1:0] instret_h;
  run_state_e       dbg_state_h;

  core_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .START_HALTED(0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ins(ins), .halt_req(halt_req),
    .resume_req(resume_req), .step_req(step_req), .step_count(step_count),
    .bp_en(bp_en), .bp_addr(bp_addr), .core_en(core_en), .halted(halted),
    .halt_cause(halt_cause), .instret(instret), .dbg_state(dbg_state)
  );

  core_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .START_HALTED(1)) dut_h (
    .clk(clk), .reset(reset), .pc(pc), .ins(ins), .halt_req(halt_req),
    .resume_req(resume_req), .step_req(step_req), .step_count(step_count),
    .bp_en(bp_en), .bp_addr(bp_addr), .core_en(core_en_h), .halted(halted_h),
    .halt_cause(halt_cause_h), .instret(instret_h), .dbg_state(dbg_state_h)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  run_state_e       m_mode;
  halt_cause_e      m_cause;
  int unsigned      m_left;
  logic             m_skip;
  logic [CNT_W-1:0] m_ret;
  logic [XLEN-1:0]  m_pc;
  logic             m_bp, m_eb, m_en;

  logic [XLEN-1:0]  eb_pc = 32'hFFFF_FFFF;
  bit               rand_ins = 1'b0;
  logic             last_en;

  task automatic model_reset();
    m_mode  = RUN;
    m_cause = CAUSE_STEP;
    m_left  = 0;
    m_skip  = 1'b0;
    m_ret   = '0;
    m_pc    = '0;
  endtask

  task automatic model_eval();
    m_bp = bp_en && (pc == bp_addr) && !m_skip;
`ifdef RUN_CTRL_EBREAK_EN
    m_eb = (ins == EBREAK_INSN) && !m_skip;
`else
    m_eb = 1'b0;
`endif
    m_en = (m_mode != HALTED) && !halt_req && !m_bp && !m_eb;
  endtask

  task automatic model_halt(input halt_cause_e c);
    m_mode  = HALTED;
    m_cause = c;
    m_left  = 0;
  endtask

  task automatic model_edge();
    m_pc = pc;
    if (m_en) begin
      m_ret  = m_ret + 1;
      m_skip = 1'b0;
      m_pc   = (pc + 32'd4) & PC_MASK;
    end
    if (m_mode == HALTED) begin
      if (!halt_req) begin
        if (step_req) begin
          m_mode = STEP;
          m_left = (step_count == 0) ? 1 : int'(step_count);
          m_skip = 1'b1;
        end else if (resume_req) begin
          m_mode = RUN;
          m_skip = 1'b1;
        end
      end
    end else if (halt_req)  model_halt(CAUSE_HALT);
    else if (m_bp)          model_halt(CAUSE_BP);
    else if (m_eb)          model_halt(CAUSE_EBREAK);
    else if (m_mode == STEP) begin
      m_left--;
      if (m_left == 0) model_halt(CAUSE_STEP);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_regs();
    chk("halted",     halted,     (m_mode == HALTED));
    chk("halt_cause", halt_cause, m_cause);
    chk("instret",    instret,    m_ret);
    chk("state",      dbg_state,  m_mode);
  endtask

  task automatic drive_ins();
    if (rand_ins) ins = ($urandom_range(0, 15) == 0) ? EBREAK_INSN : NOP;
    else          ins = (pc == eb_pc) ? EBREAK_INSN : NOP;
  endtask

  // Inputs are set after a falling edge; one call covers one full clock cycle.
  task automatic tick();
    #1;
    model_eval();
    last_en = core_en;
    chk("core_en", core_en, m_en);
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    @(negedge clk);
    pc         = m_pc;
    resume_req = 1'b0;
    step_req   = 1'b0;
    drive_ins();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_regs();
    chk("reset_halted_sh1", halted_h, 1'b1);
    chk("reset_state_sh1",  dbg_state_h, HALTED);
    chk("reset_en_sh1",     core_en_h, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pc    = '0;
    drive_ins();
  endtask

  task automatic step_and_count(input logic [CNT_W-1:0] cnt, output int commits);
    commits    = 0;
    step_req   = 1'b1;
    step_count = cnt;
    tick();
    for (int k = 0; k < 20 && !halted; k++) begin
      tick();
      commits += int'(last_en);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [CNT_W-1:0] ret0;
    @(negedge clk);

    // Free run from reset
    do_reset();
    chk("reset_instret", instret, '0);
    repeat (10) tick();
    chk("free_instret", instret, 10);
    chk("free_halted",  halted, 1'b0);

    // Breakpoint at 0x10, then resume over it
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10;
    repeat (5) tick();
    chk("bp_halted",  halted, 1'b1);
    chk("bp_cause",   halt_cause, 2'd2);
    chk("bp_instret", instret, 4);
    chk("bp_pc",      pc, 32'h10);
    repeat (2) tick();
    resume_req = 1'b1;
    tick();
    tick();
    chk("resume_pc", pc, 32'h14);
    repeat (3) tick();
    chk("resume_no_rehalt", halted, 1'b0);
    bp_en = 1'b0;

    // One-cycle halt_req mid-run
    ret0 = instret;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("hreq_halted",  halted, 1'b1);
    chk("hreq_cause",   halt_cause, 2'd1);
    chk("hreq_instret", instret, ret0);

    // Step 3 then step 0
    ret0 = instret;
    step_and_count(3, n);
    chk("step3_commits", n, 3);
    chk("step3_cause",   halt_cause, 2'd0);
    chk("step3_instret", instret, ret0 + 3);
    step_and_count(0, n);
    chk("step0_commits", n, 1);
    chk("step0_halted",  halted, 1'b1);

    // halt_req together with a breakpoint hit
    resume_req = 1'b1;
    tick();
    tick();
    bp_en = 1'b1; bp_addr = pc; halt_req = 1'b1;
    tick();
    halt_req = 1'b0; bp_en = 1'b0;
    chk("hreq_bp_cause", halt_cause, 2'd1);

    // Reset in the middle of an 8-instruction step
    ret0 = instret;
    step_req = 1'b1; step_count = 8;
    tick();
    repeat (2) tick();
    chk("midstep_instret", instret, ret0 + 2);
    do_reset();
    chk("midstep_state", dbg_state, RUN);
    chk("midstep_ret0",  instret, '0);
    repeat (3) tick();
    chk("midstep_run",   instret, 3);

`ifdef RUN_CTRL_EBREAK_EN
    // ebreak at 0x8 traps, then a single step executes it
    eb_pc = 32'h8;
    do_reset();
    repeat (3) tick();
    chk("eb_cause",   halt_cause, 2'd3);
    chk("eb_instret", instret, 2);
    step_and_count(1, n);
    chk("eb_step_commits", n, 1);
    chk("eb_step_pc",      pc, 32'hC);
    eb_pc = 32'hFFFF_FFFF;
`endif

    // Random debug-host traffic
    do_reset();
    rand_ins = 1'b1;
    drive_ins();
    for (int i = 0; i < 600; i++) begin
      halt_req   = ($urandom_range(0, 9) == 0);
      resume_req = ($urandom_range(0, 4) == 0);
      step_req   = ($urandom_range(0, 5) == 0);
      step_count = CNT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) begin
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = XLEN'($urandom_range(0, 15)) << 2;
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
